pcie_cfg_mgmt_responder: RTL and testbench
==========================================

Name: pcie_cfg_mgmt_responder

Overview:
- Completer end of the PCIe hard IP configuration management interface (cfg_mgmt_*); the requester side lives in the DMA benchmark core.
- Emulates the hard IP's config-space access port for block- and system-level simulation, and for loopback bring-up builds.
- Backed by a small DWORD register file.
- Answers each read or write strobe after a programmable latency, with a single-cycle done pulse, as the hard IP does.

Parameters:
- DEPTH, 64: number of implemented 32-bit DWORD registers; power of two, 1..1024.
- LATENCY, 3: cycles from request sample to done pulse; legal range 1..15.
- FUNC_COUNT, 1: function numbers 0..FUNC_COUNT-1 are implemented; others alias to an empty function.
- RO_LIMIT, 4: addresses below this are read-only (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- cfg_mgmt_addr  in  10  DWORD address
- cfg_mgmt_function_number  in  8  target function
- cfg_mgmt_write  in  1  write strobe; held until done
- cfg_mgmt_write_data  in  32  write data
- cfg_mgmt_byte_enable  in  4  write byte enables
- cfg_mgmt_read  in  1  read strobe; held until done
- cfg_mgmt_read_data  out  32  read data; valid only with done
- cfg_mgmt_read_write_done  out  1  one-cycle completion pulse
- protocol_error  out  1  one-cycle pulse on requester protocol violation

Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State to IDLE; latency counter to 0.
  - All register-file entries to 0.
  - cfg_mgmt_read_data, cfg_mgmt_read_write_done and protocol_error to 0.
  - Reset mid-transaction drops the transaction; no done pulse is issued.
- State machine IDLE -> WAIT -> DONE -> IDLE.
- IDLE:
  - On the first cycle with read or write high, latch addr, function, data, byte enables and op type.
  - Load counter with LATENCY-1. Go to DONE if LATENCY==1, else WAIT.
  - Read and write both high: pulse protocol_error and execute as a write.
- WAIT:
  - Decrement the counter; go to DONE when it reaches 0.
  - If the latched strobe deasserts: pulse protocol_error, abort to IDLE, no done, no register update.
- DONE:
  - Assert done for exactly one cycle (registered output).
  - Writes commit on this cycle: each byte lane i updates only if byte_enable[i] is set.
  - Reads drive read_data from the latched address on this cycle.
  - read_data is 0 in every cycle done is low, and on write completions.
  - Next state is IDLE.
- Request timing: a strobe still high in the IDLE cycle after done starts a new request, so the minimum cycle period is LATENCY+1 clocks.
- Done latency: done rises LATENCY cycles after the cycle the strobe is first sampled high in IDLE.
- Out of range:
  - Covers addr >= DEPTH, and function_number >= FUNC_COUNT.
  - Reads return 32'h0; writes are discarded; done still pulses normally.
  - With FUNC_COUNT>1, each function has its own DEPTH-entry bank; index = function*DEPTH + addr.
- Address-change check: addr or function changing while in WAIT is not checked; the latched values are used.

Optional Feature:
- Macro: PCIE_CFG_MGMT_RO_PROTECT_EN.
- Defined:
  - Addresses below RO_LIMIT in every implemented function are read-only.
  - Writes to them complete with a normal done pulse but leave contents unchanged.
  - Reset value of those entries is {16'h1234, 16'h10EE} at addr 0 and 0 elsewhere.
- Undefined: all addresses are writable, and all reset values are 0.

Test Plan:
- Reset: rst_n low mid-WAIT -> done and read_data 0 immediately; after release, read addr 0 returns 0 (feature off).
- Basic write/read: write addr 5, data 32'hDEADBEEF, BE 4'hF, LATENCY 3 -> done 3 cycles after sample; a following read of addr 5 returns 32'hDEADBEEF with done.
- Byte enables: addr 5 holds 32'hDEADBEEF; write 32'h11223344 with BE 4'b0101 -> readback 32'hDE22BE44.
- Out of range: write then read addr 10'h3FF with DEPTH 64, and function 2 with FUNC_COUNT 1 -> done pulses, read_data 0, no other entry altered.
- Protocol errors: read and write together -> protocol_error one cycle, write performed; read dropped at WAIT cycle 1 -> protocol_error, no done.
- Feature on: write 32'hFFFFFFFF to addr 0 -> done; readback 32'h123410EE. Write to addr RO_LIMIT -> readback 32'hFFFFFFFF.

Source files
------------

// File: rtl/pcie_cfg_mgmt_responder.sv
`default_nettype none
// ============================================================================
// Module   : pcie_cfg_mgmt_responder
// Purpose  : Completer side of the PCIe hard IP cfg_mgmt_* port. Accepts one
//            read or write request at a time. Each request is answered after
//            LATENCY cycles with a single-cycle done pulse. A DWORD register
//            file (DEPTH entries per implemented function) backs the port.
// Ports    : clk, rst_n (async, active-low)
//            cfg_mgmt_addr[9:0], cfg_mgmt_function_number[7:0]
//            cfg_mgmt_write, cfg_mgmt_write_data[31:0], cfg_mgmt_byte_enable[3:0]
//            cfg_mgmt_read
//            cfg_mgmt_read_data[31:0], cfg_mgmt_read_write_done, protocol_error
// Option   : PCIE_CFG_MGMT_RO_PROTECT_EN - addresses below RO_LIMIT in every
//            function are read-only; address 0 resets to 32'h123410EE.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_cfg_mgmt_responder #(
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 3,
  parameter int FUNC_COUNT = 1,
  parameter int RO_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  cfg_mgmt_addr,
  input  logic [7:0]  cfg_mgmt_function_number,
  input  logic        cfg_mgmt_write,
  input  logic [31:0] cfg_mgmt_write_data,
  input  logic [3:0]  cfg_mgmt_byte_enable,
  input  logic        cfg_mgmt_read,
  output logic [31:0] cfg_mgmt_read_data,
  output logic        cfg_mgmt_read_write_done,
  output logic        protocol_error
);

  localparam int          ENTRIES = DEPTH * FUNC_COUNT;
  localparam int          IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
  localparam logic [31:0] ID_RST  = {16'h1234, 16'h10EE};

`ifdef PCIE_CFG_MGMT_RO_PROTECT_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [9:0]  addr_q;
  logic [7:0]  func_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        is_wr_q;
  logic        done_q;
  logic [31:0] rdata_q;
  logic        perr_q;

  logic [31:0] mem_q [ENTRIES];

  logic             w_in_range;
  logic             w_ro;
  logic             w_strobe;
  logic             w_commit;
  logic [IDX_W-1:0] w_idx;

  // Everything below works from the latched request; the live address and
  // function inputs are ignored once a request has been accepted.
  assign w_in_range = (32'(addr_q) < 32'(DEPTH)) && (32'(func_q) < 32'(FUNC_COUNT));
  assign w_idx      = IDX_W'(func_q) * IDX_W'(DEPTH) + IDX_W'(addr_q);
  assign w_ro       = RO_EN && (32'(addr_q) < 32'(RO_LIMIT));
  // The strobe that must stay high: write wins when both were raised.
  assign w_strobe   = is_wr_q ? cfg_mgmt_write : cfg_mgmt_read;
  assign w_commit   = (state_q == S_DONE) && is_wr_q && w_in_range && !w_ro;

  // Request sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 10'd0;
      func_q  <= 8'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      is_wr_q <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
      perr_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
      perr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_mgmt_read || cfg_mgmt_write) begin
            addr_q  <= cfg_mgmt_addr;
            func_q  <= cfg_mgmt_function_number;
            wdata_q <= cfg_mgmt_write_data;
            be_q    <= cfg_mgmt_byte_enable;
            is_wr_q <= cfg_mgmt_write;
            cnt_q   <= LAT_M1;
            perr_q  <= cfg_mgmt_read && cfg_mgmt_write;
            state_q <= (LATENCY == 1) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_strobe) begin
            // Requester gave up early: flag it and drop the request silently.
            perr_q  <= 1'b1;
            cnt_q   <= 4'd0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          if (!is_wr_q && w_in_range) begin
            rdata_q <= mem_q[w_idx];
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Register file; writes land on the done cycle, lane by lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= (RO_EN && ((i % DEPTH) == 0)) ? ID_RST : 32'd0;
      end
    end else if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign cfg_mgmt_read_data       = rdata_q;
  assign cfg_mgmt_read_write_done = done_q;
  assign protocol_error           = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_cfg_mgmt_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_cfg_mgmt_responder
// Purpose  : Directed, self-checking bench for pcie_cfg_mgmt_responder.
//            Each request posts its expected done/read_data/protocol_error per
//            cycle into tables; one monitor compares the DUT against them
//            every cycle. Literal readbacks pin the model.
// Option   : PCIE_CFG_MGMT_RO_PROTECT_EN enables the read-only tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_cfg_mgmt_responder;

  localparam int LAT = 3;
  localparam int DEP = 64;
  localparam int NF  = 1;
  localparam int ROL = 4;
`ifdef PCIE_CFG_MGMT_RO_PROTECT_EN
  localparam bit RO_ON = 1'b1;
`else
  localparam bit RO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  addr = '0;
  logic [7:0]  func = '0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        rd = 1'b0;
  logic [31:0] rdata;
  logic        done;
  logic        perr;

  pcie_cfg_mgmt_responder #(
    .DEPTH(DEP), .LATENCY(LAT), .FUNC_COUNT(NF), .RO_LIMIT(ROL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_mgmt_addr(addr),
    .cfg_mgmt_function_number(func),
    .cfg_mgmt_write(wr),
    .cfg_mgmt_write_data(wdata),
    .cfg_mgmt_byte_enable(be),
    .cfg_mgmt_read(rd),
    .cfg_mgmt_read_data(rdata),
    .cfg_mgmt_read_write_done(done),
    .protocol_error(perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [DEP*NF];
  bit          exp_done [int];
  logic [31:0] exp_rd   [int];
  bit          exp_pe   [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic bit in_rng(input int a, input int f);
    return (a < DEP) && (f < NF);
  endfunction

  function automatic bit is_ro(input int a);
    return RO_ON && (a < ROL);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEP*NF; i++) model[i] = ((i % DEP) == 0 && RO_ON) ? 32'h1234_10EE : 32'h0;
    exp_done.delete();
    exp_rd.delete();
    exp_pe.delete();
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Per-cycle monitor: anything not posted in the tables must be 0.
  initial begin
    logic [31:0] er;
    bit ed, ep;
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ed = 1'b0; er = 32'h0; ep = 1'b0;
      end else begin
        ed = exp_done.exists(cyc) ? exp_done[cyc] : 1'b0;
        er = exp_rd.exists(cyc) ? exp_rd[cyc] : 32'h0;
        ep = exp_pe.exists(cyc) ? exp_pe[cyc] : 1'b0;
      end
      chk("mon_done", {31'b0, done}, {31'b0, ed});
      chk("mon_rdata", rdata, er);
      chk("mon_perr", {31'b0, perr}, {31'b0, ep});
    end
  end

  // Starts a request and posts its expectations; returns the done cycle.
  task automatic issue(input bit r, input bit w, input int a, input int f,
                       input logic [31:0] d, input logic [3:0] b, output int dn);
    int s;
    @(posedge clk);
    #1;
    addr = 10'(a); func = 8'(f); wdata = d; be = b; rd = r; wr = w;
    s  = cyc + 1;
    dn = s + LAT;
    exp_done[dn] = 1'b1;
    if (r && w) exp_pe[s] = 1'b1;
    if (w) begin
      exp_rd[dn] = 32'h0;
      if (in_rng(a, f) && !is_ro(a)) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) model[f*DEP+a][8*k +: 8] = d[8*k +: 8];
      end
    end else begin
      exp_rd[dn] = in_rng(a, f) ? model[f*DEP+a] : 32'h0;
    end
  endtask

  task automatic xact(input bit r, input bit w, input int a, input int f,
                      input logic [31:0] d, input logic [3:0] b, output logic [31:0] got);
    int dn;
    issue(r, w, a, f, d, b, dn);
    wait_edge(dn);
    got = rdata;
    rd = 1'b0; wr = 1'b0;
  endtask

  // Strobe dropped after the first WAIT cycle: error pulse, no completion.
  task automatic abort_req(input bit w, input int a, input logic [31:0] d);
    int s;
    @(posedge clk);
    #1;
    addr = 10'(a); func = 8'd0; wdata = d; be = 4'hF; rd = !w; wr = w;
    s = cyc + 1;
    wait_edge(s);
    rd = 1'b0; wr = 1'b0;
    exp_pe[s+1] = 1'b1;
    wait_edge(s + LAT + 2);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] got;
    int s1, d1, d2, dn;

    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset contents.
    xact(1, 0, 0, 0, 32'h0, 4'h0, got);
    chk("rst_rd0", got, RO_ON ? 32'h1234_10EE : 32'h0);

    // Basic write / read with latency check.
    issue(0, 1, 5, 0, 32'hDEAD_BEEF, 4'hF, dn);
    wait_edge(dn - 1);
    chk("done_early", {31'b0, done}, 32'h0);
    wait_edge(dn);
    chk("done_at_lat", {31'b0, done}, 32'h1);
    wr = 1'b0;
    xact(1, 0, 5, 0, 32'h0, 4'h0, got);
    chk("rd5", got, 32'hDEAD_BEEF);

    // Byte enables.
    xact(0, 1, 5, 0, 32'h1122_3344, 4'b0101, got);
    xact(1, 0, 5, 0, 32'h0, 4'h0, got);
    chk("rd5_be", got, 32'hDE22_BE44);

    // Out of range accesses: done still pulses, nothing stored.
    xact(0, 1, 10'h3FF, 0, 32'hCAFE_F00D, 4'hF, got);
    xact(0, 1, 5, 2, 32'h1234_5678, 4'hF, got);
    xact(1, 0, 10'h3FF, 0, 32'h0, 4'h0, got);
    chk("rd_oor_addr", got, 32'h0);
    xact(1, 0, 5, 2, 32'h0, 4'h0, got);
    chk("rd_oor_func", got, 32'h0);
    xact(1, 0, 63, 0, 32'h0, 4'h0, got);
    chk("rd63_alias", got, 32'h0);
    xact(1, 0, 5, 0, 32'h0, 4'h0, got);
    chk("rd5_kept", got, 32'hDE22_BE44);

    // Read and write together: error pulse, executes as write.
    xact(1, 1, 9, 0, 32'hA5A5_A5A5, 4'hF, got);
    chk("both_rdata", got, 32'h0);
    xact(1, 0, 9, 0, 32'h0, 4'h0, got);
    chk("rd9", got, 32'hA5A5_A5A5);

    // Aborted read and aborted write.
    abort_req(0, 9, 32'h0);
    abort_req(1, 9, 32'h0000_0000);
    xact(1, 0, 9, 0, 32'h0, 4'h0, got);
    chk("rd9_after_abort", got, 32'hA5A5_A5A5);

    // Strobe held through done: a second request starts right after.
    @(posedge clk);
    #1;
    addr = 10'd5; func = 8'd0; rd = 1'b1;
    s1 = cyc + 1;
    d1 = s1 + LAT;
    d2 = d1 + 1 + LAT;
    exp_done[d1] = 1'b1; exp_rd[d1] = model[5];
    exp_done[d2] = 1'b1; exp_rd[d2] = model[5];
    wait_edge(d2);
    chk("b2b_rd", rdata, 32'hDE22_BE44);
    rd = 1'b0;

    // Async reset while done is high clears outputs at once.
    issue(1, 0, 9, 0, 32'h0, 4'h0, dn);
    wait_edge(dn);
    rst_n = 1'b0;
    #1;
    chk("rst_done_now", {31'b0, done}, 32'h0);
    chk("rst_rdata_now", rdata, 32'h0);
    reset_pulse();
    xact(1, 0, 5, 0, 32'h0, 4'h0, got);
    chk("rd5_after_rst", got, 32'h0);

    // Reset in the middle of WAIT: no done, no write.
    issue(0, 1, 7, 0, 32'h7777_7777, 4'hF, dn);
    wait_edge(dn - LAT + 1);
    reset_pulse();
    repeat (LAT + 1) @(posedge clk);
    #1;
    xact(1, 0, 7, 0, 32'h0, 4'h0, got);
    chk("rd7_after_rst", got, 32'h0);

`ifdef PCIE_CFG_MGMT_RO_PROTECT_EN
    xact(0, 1, 0, 0, 32'hFFFF_FFFF, 4'hF, got);
    xact(1, 0, 0, 0, 32'h0, 4'h0, got);
    chk("ro_rd0", got, 32'h1234_10EE);
    xact(0, 1, ROL, 0, 32'hFFFF_FFFF, 4'hF, got);
    xact(1, 0, ROL, 0, 32'h0, 4'h0, got);
    chk("rw_rdlim", got, 32'hFFFF_FFFF);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
